arm_boot_loader: RTL
====================

Name: arm_boot_loader

Overview:
- Sequences program load into arm_memory port 2, then releases arm_core from reset.
- Accepts a 32-bit word stream, writes each word to consecutive word addresses and holds the core in reset throughout.
- After the last word, hands memory port 2 to the core and reports halt.
- Sits between the load source, arm_core and arm_memory, in place of bench-driven loading.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of first loaded word (word-aligned)
- MAX_WORDS, 1024, maximum words accepted per load (1..65535)

Ports:
- clk  in  1  system clock, all logic on posedge
- rst  in  1  synchronous reset, active-low (rst==0 at posedge resets)
- start  in  1  one-cycle pulse, begins a load; honoured only in IDLE
- ld_valid  in  1  load word valid
- ld_data  in  32  load word
- ld_last  in  1  qualifies ld_data as final program word
- ld_ready  out  1  loader accepts word this cycle
- core_mem_addr  in  32  core data-port address
- core_mem_data_in  in  32  core write data
- core_mem_write_en  in  1  core write enable
- core_halted  in  1  arm_core halted
- mem_addr  out  32  to arm_memory addr2
- mem_data_in  out  32  to arm_memory data_in2
- mem_write_en  out  1  to arm_memory we[1]
- core_rst  out  1  active-high reset to arm_core
- running  out  1  core released, in RUN
- done  out  1  core halted after successful load (sticky)
- error  out  1  load failed (sticky until reset or new start)
- word_count  out  16  words written in current/last load

Behaviour:
- Reset (rst==0): state IDLE, core_rst=1, mem_write_en=0, mem_addr=0, mem_data_in=0, ld_ready=0, running=0, done=0, error=0, word_count=0.
- States: IDLE, LOAD, START, RUN, HALT, ERROR.
- IDLE: core_rst=1, ld_ready=0. On start go to LOAD, clear word_count, error and done, and set write pointer to BASE_ADDR.
- LOAD: ld_ready=1. A word is accepted when ld_valid&&ld_ready.
  - Next cycle: mem_write_en=1 for exactly one cycle, mem_addr=pointer, mem_data_in=word.
  - Pointer += 4 (wraps mod 2^32); word_count += 1.
  - Back-to-back accepts give back-to-back writes; throughput is 1 word/cycle.
  - Idle cycles with no accept: mem_write_en=0.
- Overflow: a word accepted while word_count==MAX_WORDS goes to ERROR. That word is not written.
- On ld_last accept (not overflowing), go to START. The last write is issued during the START cycle.
- START: ld_ready=0. Next cycle go to RUN.
- RUN: core_rst=0, running=1, ld_ready=0.
  - mem_addr, mem_data_in and mem_write_en are driven combinationally from core_mem_*.
  - core_halted==1 goes to HALT.
- HALT: done=1, running=0, core_rst stays 0. Memory port 2 stays muxed to the core (post-mortem reads). start returns to LOAD via IDLE semantics and reasserts core_rst.
- ERROR: error=1, core_rst=1, mem_write_en=0, ld_ready=0. start restarts the load.
- Loader-owned states (IDLE/LOAD/START/ERROR): core_mem_* inputs ignored.
- start outside IDLE/HALT/ERROR: ignored.
- rst==0 mid-load: abort immediately, apply reset values. A partially written memory is left as is.

Optional Feature:
- Macro: BOOT_CHECKSUM_EN
- Defined:
  - After the ld_last accept, state CSUM: ld_ready=1, next accepted word is the checksum and is not written.
  - Checksum = 32-bit wrapping sum of all written words.
  - Match: go to START; the last program word's write completes during CSUM or earlier.
  - Mismatch: go to ERROR, core_rst stays 1.
  - Overflow rules unchanged; the checksum word does not count.
- Undefined: CSUM state and sum logic absent. ld_last goes directly to START.

Test Plan:
- Reset then start. Stream 0xE3A00001, 0xE3A01002, 0xEF000000 (last) back-to-back -> writes at addr 0,4,8 on consecutive cycles; word_count=3; core_rst falls 2 cycles after the last accept; running=1.
- In RUN, drive core_mem_addr=0x40, core_mem_data_in=0x55, core_mem_write_en=1 -> mem_* mirror these the same cycle. Raise core_halted -> done=1, running=0 next cycle.
- ld_valid gaps (valid every third cycle) -> mem_write_en pulses only after accepts; addresses stay contiguous.
- MAX_WORDS=2, send 3 words with the last flagged on the third -> only addrs 0,4 written; error=1; core_rst=1.
- rst low for one cycle after 2 of 4 words -> all outputs at reset values; a fresh start reloads from BASE_ADDR.
- BOOT_CHECKSUM_EN: words 1,2,3 (last) then checksum 6 -> RUN. Repeat with checksum 7 -> ERROR, core stays in reset.

Source files
------------

// File: rtl/arm_boot_loader.sv
// Boot loader: streams a program into arm_memory port 2, then releases arm_core from reset.
// Optional BOOT_CHECKSUM_EN adds a trailing checksum word that must match before the core starts.
module arm_boot_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        ld_valid,
  input  logic [31:0] ld_data,
  input  logic        ld_last,
  output logic        ld_ready,
  input  logic [31:0] core_mem_addr,
  input  logic [31:0] core_mem_data_in,
  input  logic        core_mem_write_en,
  input  logic        core_halted,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_data_in,
  output logic        mem_write_en,
  output logic        core_rst,
  output logic        running,
  output logic        done,
  output logic        error,
  output logic [15:0] word_count
);

  localparam logic [15:0] MAX_CNT = 16'(MAX_WORDS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_RUN,
    S_HALT,
    S_ERROR
`ifdef BOOT_CHECKSUM_EN
    , S_CSUM
`endif
  } state_t;

  state_t      state_reg;
  logic [31:0] ptr_reg;
  logic [15:0] word_count_reg;
  logic [31:0] mem_addr_reg;
  logic [31:0] mem_data_reg;
  logic        mem_we_reg;
  logic        ld_ready_reg;
  logic        core_rst_reg;
  logic        running_reg;
  logic        done_reg;
  logic        error_reg;
`ifdef BOOT_CHECKSUM_EN
  logic [31:0] sum_reg;
`endif

  logic accept;
  logic begin_load;
  logic core_owned;

  assign accept     = ld_valid && ld_ready_reg;
  assign begin_load = start && ((state_reg == S_IDLE) || (state_reg == S_HALT) ||
                                (state_reg == S_ERROR));
  // Once the core is out of reset it owns memory port 2, including post-mortem in HALT.
  assign core_owned = (state_reg == S_RUN) || (state_reg == S_HALT);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg      <= S_IDLE;
      ptr_reg        <= BASE_ADDR;
      word_count_reg <= 16'd0;
      mem_addr_reg   <= 32'd0;
      mem_data_reg   <= 32'd0;
      mem_we_reg     <= 1'b0;
      ld_ready_reg   <= 1'b0;
      core_rst_reg   <= 1'b1;
      running_reg    <= 1'b0;
      done_reg       <= 1'b0;
      error_reg      <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
      sum_reg        <= 32'd0;
`endif
    end else begin
      mem_we_reg <= 1'b0;
      if (begin_load) begin
        state_reg      <= S_LOAD;
        ptr_reg        <= BASE_ADDR;
        word_count_reg <= 16'd0;
        ld_ready_reg   <= 1'b1;
        core_rst_reg   <= 1'b1;
        running_reg    <= 1'b0;
        done_reg       <= 1'b0;
        error_reg      <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
        sum_reg        <= 32'd0;
`endif
      end else begin
        case (state_reg)
          S_LOAD: begin
            if (accept) begin
              if (word_count_reg == MAX_CNT) begin
                // Overflowing word is dropped, not written.
                state_reg    <= S_ERROR;
                ld_ready_reg <= 1'b0;
                error_reg    <= 1'b1;
              end else begin
                mem_we_reg     <= 1'b1;
                mem_addr_reg   <= ptr_reg;
                mem_data_reg   <= ld_data;
                ptr_reg        <= ptr_reg + 32'd4;
                word_count_reg <= word_count_reg + 16'd1;
`ifdef BOOT_CHECKSUM_EN
                sum_reg        <= sum_reg + ld_data;
                if (ld_last) begin
                  state_reg <= S_CSUM;
                end
`else
                if (ld_last) begin
                  state_reg    <= S_START;
                  ld_ready_reg <= 1'b0;
                end
`endif
              end
            end
          end
`ifdef BOOT_CHECKSUM_EN
          S_CSUM: begin
            if (accept) begin
              ld_ready_reg <= 1'b0;
              if (ld_data == sum_reg) begin
                state_reg <= S_START;
              end else begin
                state_reg <= S_ERROR;
                error_reg <= 1'b1;
              end
            end
          end
`endif
          S_START: begin
            state_reg    <= S_RUN;
            core_rst_reg <= 1'b0;
            running_reg  <= 1'b1;
          end
          S_RUN: begin
            if (core_halted) begin
              state_reg   <= S_HALT;
              running_reg <= 1'b0;
              done_reg    <= 1'b1;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign mem_addr     = core_owned ? core_mem_addr     : mem_addr_reg;
  assign mem_data_in  = core_owned ? core_mem_data_in  : mem_data_reg;
  assign mem_write_en = core_owned ? core_mem_write_en : mem_we_reg;
  assign ld_ready     = ld_ready_reg;
  assign core_rst     = core_rst_reg;
  assign running      = running_reg;
  assign done         = done_reg;
  assign error        = error_reg;
  assign word_count   = word_count_reg;

endmodule
